// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one frame at a time to a single UART
// transmitter, with a per-state timeout guarding the transmitter handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_WD = 8,
    parameter int TIMEOUT = 4096,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_WD-1:0] req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       tx_start,
    output logic [DATA_WD-1:0]         din,
    input  logic                       uart_busy,
    output logic                       active,
    output logic [IW-1:0]              cur_id
);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        LAUNCH   = 3'b010,
        WAIT_END = 3'b100
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_WD-1:0]   din_q, din_d;
    logic [IW-1:0]        cur_id_q, cur_id_d;
    logic                 active_q, active_d;

    logic                 found;
    logic [IW-1:0]        win;
    int                   idx;

    // Scan upward from ptr, wrapping, and take the first pending request.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        done_d     = '0;
        err_d      = '0;
        tx_start_d = tx_start_q;
        din_d      = din_q;
        cur_id_d   = cur_id_q;
        unique case (state_q)
            IDLE: begin
                cnt_d      = '0;
                tx_start_d = 1'b0;
                if (found) begin
                    state_d    = LAUNCH;
                    din_d      = req_data[int'(win)*DATA_WD +: DATA_WD];
                    cur_id_d   = win;
                    gnt_d[win] = 1'b1;
                    ptr_d      = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                    tx_start_d = 1'b1;
                end
            end
            LAUNCH: begin
                // busy is checked first so a same-cycle timeout loses
                if (uart_busy) begin
                    state_d    = WAIT_END;
                    tx_start_d = 1'b0;
                    cnt_d      = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d         = IDLE;
                    tx_start_d      = 1'b0;
                    err_d[cur_id_q] = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_END: begin
                if (!uart_busy) begin
                    state_d          = IDLE;
                    done_d[cur_id_q] = 1'b1;
                    cnt_d            = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d         = IDLE;
                    err_d[cur_id_q] = 1'b1;
                    cnt_d           = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            tx_start_q <= 1'b0;
            din_q      <= '0;
            cur_id_q   <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
            cur_id_q   <= cur_id_d;
            active_q   <= active_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign cur_id   = cur_id_q;
    assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level
// round-robin model; a second instance uses a short timeout.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt, done, err;
    logic        tx_start, busy, active;
    logic [7:0]  din;
    logic [1:0]  cur_id;

    logic [3:0]  req2;
    logic [31:0] req_data2;
    logic [3:0]  gnt2, done2, err2;
    logic        tx_start2, busy2, active2;
    logic [7:0]  din2;
    logic [1:0]  cur_id2;

    logic [7:0]  data_m [4];
    int          ptr_m;
    int          total;
    int          bad;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WD(8), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .tx_start(tx_start),
        .din(din), .uart_busy(busy), .active(active), .cur_id(cur_id)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_WD(8), .TIMEOUT(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2),
        .gnt(gnt2), .done(done2), .err(err2), .tx_start(tx_start2),
        .din(din2), .uart_busy(busy2), .active(active2), .cur_id(cur_id2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = data_m[i];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("excl", 32'($countones({gnt, done, err}) <= 1), 1);
            chk("excl2", 32'($countones({gnt2, done2, err2}) <= 1), 1);
        end
    end

    // One frame on the main instance: the model picks the winner, the bench
    // plays the serializer (busy after d tx_start cycles, held for hold).
    task automatic serve(input int d, input int hold, input bit drop);
        int n, tx_hi, w, k;
        logic [3:0] oh;
        w = -1;
        for (int i = 0; i < 4; i++) begin
            k = (ptr_m + i) % 4;
            if (w < 0 && req[k]) w = k;
        end
        if (w < 0) w = 0;
        oh = 4'(1 << w);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 50);
        chk("gnt", gnt, oh);
        chk("din", din, data_m[w]);
        chk("cur_id", cur_id, w);
        ptr_m = (w + 1) % 4;
        if (drop) req[w] = 1'b0;
        tx_hi = 0;
        for (int j = 0; j < d; j++) begin
            if (j > 0) @(negedge clk);
            tx_hi += int'(tx_start);
        end
        busy = 1'b1;
        @(negedge clk);
        tx_hi += int'(tx_start);
        chk("tx_len", tx_hi, d);
        repeat (hold - 1) @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        chk("done", done, oh);
        chk("err", err, 0);
        chk("active", active, 0);
    endtask

    initial begin
        int n, tx_hi;
        bit done_seen;
        total = 0;
        bad = 0;
        ptr_m = 0;
        rst_n = 1'b0;
        req = '0;
        busy = 1'b0;
        req2 = '0;
        busy2 = 1'b0;
        req_data2 = 32'h44332211;
        for (int i = 0; i < 4; i++) data_m[i] = 8'(8'h10 + i);
        #1;
        chk("rst_out", {gnt, done, err, tx_start, din, cur_id, active}, 0);
        chk("rst_out2", {gnt2, done2, err2, tx_start2, din2, cur_id2, active2}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        req = 4'b1111;
        repeat (6) serve(2, 5, 1'b0);
        req = 4'b1010;
        serve(1, 3, 1'b1);
        serve(3, 4, 1'b1);

        req = 4'b0001;
        data_m[0] = 8'hA5;
        serve(2, 160, 1'b1);

        req = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0 && n < 50);
        chk("gnt_pre_rst", gnt, 4'b0100);
        req = '0;
        busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("id_pre_rst", cur_id, 2);
        chk("act_pre_rst", active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {gnt, done, err, tx_start, din, cur_id, active}, 0);
        busy = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        serve(1, 5, 1'b1);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) data_m[i] = 8'($urandom);
            req = req | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = req & 4'($urandom_range(0, 15));
            if (req == 4'b0) req = 4'(1 << $urandom_range(0, 3));
            serve($urandom_range(1, 4), $urandom_range(1, 30), 1'b1);
        end
        req = '0;

        req2 = 4'b0100;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt2 == 4'b0 && n < 50);
        chk("gnt2", gnt2, 4'b0100);
        chk("din2", din2, 8'h33);
        req2 = '0;
        tx_hi = 0;
        done_seen = 1'b0;
        n = 0;
        while (err2 == 4'b0 && n < 40) begin
            tx_hi += int'(tx_start2);
            done_seen |= (done2 != 4'b0);
            @(negedge clk);
            n++;
        end
        chk("to_err", err2, 4'b0100);
        chk("to_len", tx_hi, 16);
        chk("to_tx", tx_start2, 0);
        chk("to_act", active2, 0);
        chk("to_done", done_seen, 0);

        req2 = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt2 == 4'b0 && n < 50);
        chk("tie_gnt", gnt2, 4'b0001);
        req2 = '0;
        tx_hi = 0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            tx_hi += int'(tx_start2);
        end
        busy2 = 1'b1;
        @(negedge clk);
        chk("tie_len", tx_hi, 16);
        chk("tie_err", err2, 0);
        chk("tie_tx", tx_start2, 0);
        chk("tie_act", active2, 1);
        done_seen = 1'b0;
        n = 0;
        while (err2 == 4'b0 && n < 40) begin
            done_seen |= (done2 != 4'b0);
            @(negedge clk);
            n++;
        end
        chk("wait_to_err", err2, 4'b0001);
        chk("wait_to_len", n, 16);
        chk("wait_to_done", done_seen, 0);
        busy2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_act2", active2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
